max_min_scan_ip: RTL and testbench



---
 rtl/max_min_scan_ip.sv | 170 +++++++++++++++++
 tb/tb_max_min_scan_ip.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_min_scan_ip.sv
// Avalon-MM sample buffer with a sequential max/min scanner.
// Software pushes up to DEPTH samples, then START scans them one per cycle.
module max_min_scan_ip #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iChipselect_n,
  input  logic        iWrite_n,
  input  logic        iRead_n,
  input  logic [1:0]  iAddress,
  input  logic [31:0] iData,
  output logic [31:0] oData
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     count;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] best;
  logic [AW-1:0]     best_idx;
  logic [DATA_W-1:0] result;
  logic [AW-1:0]     result_idx;
  logic              result_signed;
  logic              scan_min;
  logic              scan_signed;
  logic              done;
  logic              overflow;
  logic              empty_start;

  logic wr, rd, ctrl_wr, clear_cmd, start_cmd, push_cmd, push_ok;
  logic busy, full, last;
  logic [DATA_W-1:0] sample;
  logic gt, lt, better;
  logic [31:0] status, result_ext, rdata;

  assign wr        = !iChipselect_n && !iWrite_n;
  assign rd        = !iChipselect_n && !iRead_n;
  assign ctrl_wr   = wr && (iAddress == 2'd0);
  // CLEAR has priority over START in the same CTRL write.
  assign clear_cmd = ctrl_wr && iData[3];
  assign start_cmd = ctrl_wr && iData[0] && !iData[3];
  assign push_cmd  = wr && (iAddress == 2'd1);

  assign busy    = (state != S_IDLE);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push_cmd && !busy && !full;
  assign last    = (CW'(idx) == count - CW'(1));

  assign sample = mem[idx];
  assign gt     = scan_signed ? ($signed(sample) > $signed(best)) : (sample > best);
  assign lt     = scan_signed ? ($signed(sample) < $signed(best)) : (sample < best);
  assign better = scan_min ? lt : gt;

  // NOTE: the sample buffer has no reset; its contents are don't-care until
  // pushed, and leaving it unreset keeps it mappable to plain RAM.
  always_ff @(posedge iClk) begin
    if (push_ok) mem[count[AW-1:0]] <= iData[DATA_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) state <= S_IDLE;
    else           state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (start_cmd && (count != '0)) next_state = S_SCAN;
      S_SCAN: if (last) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (clear_cmd) next_state = S_IDLE;
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      count         <= '0;
      idx           <= '0;
      best          <= '0;
      best_idx      <= '0;
      result        <= '0;
      result_idx    <= '0;
      result_signed <= 1'b0;
      scan_min      <= 1'b0;
      scan_signed   <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      empty_start   <= 1'b0;
    end else if (clear_cmd) begin
      count       <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      empty_start <= 1'b0;
    end else begin
      if (push_cmd) begin
        if (push_ok) count <= count + CW'(1);
        else         overflow <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (start_cmd) begin
            if (count != '0) begin
              scan_min    <= iData[1];
              scan_signed <= iData[2];
              done        <= 1'b0;
              idx         <= '0;
            end else begin
              done          <= 1'b1;
              empty_start   <= 1'b1;
              result        <= '0;
              result_idx    <= '0;
              result_signed <= iData[2];
            end
          end
        end
        S_SCAN: begin
          // Strict improvement only, so ties keep the lowest index.
          if ((idx == '0) || better) begin
            best     <= sample;
            best_idx <= idx;
          end
          if (!last) idx <= idx + AW'(1);
        end
        S_DONE: begin
          result        <= best;
          result_idx    <= best_idx;
          result_signed <= scan_signed;
          done          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign status     = {8'h00, 16'(count), 4'h0, empty_start, overflow, done, busy};
  assign result_ext = result_signed ? 32'($signed(result)) : 32'(result);

  always_comb begin
    rdata = '0;
    unique case (iAddress)
      2'd0: rdata = status;
      2'd1: rdata = 32'(count);
      2'd2: rdata = result_ext;
      2'd3: rdata = 32'(result_idx);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)  oData <= '0;
    else if (rd)    oData <= rdata;
  end

endmodule

// File: tb/tb_max_min_scan_ip.sv
// Self-checking bench for max_min_scan_ip with a queue-based reference model.
module tb_max_min_scan_ip;

  localparam int W = 16;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        rd_n = 1'b1;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] odata;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] q[$];

  max_min_scan_ip #(.DATA_W(W), .DEPTH(D)) dut (
    .iClk(clk), .iReset_n(rst_n), .iChipselect_n(cs_n), .iWrite_n(wr_n),
    .iRead_n(rd_n), .iAddress(addr), .iData(wdata), .oData(odata)
  );

  always #5 clk = ~clk;

  // One bus cycle: drive at negedge, sample #1 after the posedge, release.
  task automatic cyc(input bit we, input bit re, input logic [1:0] a,
                     input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    cs_n = !(we || re); wr_n = !we; rd_n = !re; addr = a; wdata = d;
    @(posedge clk);
    #1;
    r = odata;
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    cyc(1'b1, 1'b0, a, d, r);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] r);
    cyc(1'b0, 1'b1, a, 32'h0, r);
  endtask

  task automatic idle(input int n);
    logic [31:0] r;
    repeat (n) cyc(1'b0, 1'b0, 2'd0, 32'h0, r);
  endtask

  task automatic m_clear();
    wr(2'd0, 32'h8);
    q.delete();
  endtask

  task automatic m_push(input logic [W-1:0] d);
    wr(2'd1, 32'(d));
    if (q.size() < D) q.push_back(d);
  endtask

  function automatic longint sval(input logic [W-1:0] s, input bit sg);
    if (sg) return longint'($signed(s));
    return longint'(s);
  endfunction

  // Reference: first index holding the extreme value, result extended by mode.
  task automatic ref_scan(input bit mn, input bit sg, output logic [31:0] val,
                          output logic [31:0] index);
    longint bv;
    longint v;
    bv = 0;
    index = 0;
    foreach (q[i]) begin
      v = sval(q[i], sg);
      if (i == 0 || (mn ? (v < bv) : (v > bv))) begin
        bv = v;
        index = i;
      end
    end
    val = bv[31:0];
  endtask

  // START at edge E, then poll STATUS; lat is the first k with done=1, busy=0.
  task automatic do_scan(input logic [31:0] ctrl, output int lat, output bit busy_ok);
    logic [31:0] s;
    wr(2'd0, ctrl);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      rd(2'd0, s);
      if (s[1] && !s[0]) begin
        lat = k;
        break;
      end
      if (!s[0]) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), r);
      tests_run++;
      if (r !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_addr%0d: got %h expected 00000000", a, r);
      end
    end
  endtask

  task automatic test_unsigned_max();
    int lat;
    bit bok;
    logic [31:0] s, r, ix;
    m_clear();
    m_push(16'd5); m_push(16'd300); m_push(16'd17); m_push(16'd300);
    do_scan(32'h1, lat, bok);
    tests_run++;
    if (lat !== 6 || !bok) begin
      tests_failed++;
      $display("FAIL umax_latency: got %0d busy_ok=%0d expected 6 busy_ok=1", lat, bok);
    end
    rd(2'd0, s);
    tests_run++;
    if (s !== 32'h0000_0402) begin
      tests_failed++;
      $display("FAIL umax_status: got %h expected 00000402", s);
    end
    rd(2'd2, r);
    rd(2'd3, ix);
    tests_run++;
    if (r !== 32'd300 || ix !== 32'd1) begin
      tests_failed++;
      $display("FAIL umax_result: got %0d/%0d expected 300/1", r, ix);
    end
  endtask

  task automatic test_signed_minmax();
    int lat;
    bit bok;
    logic [31:0] r, ix;
    m_clear();
    m_push(16'h0003); m_push(16'hFFF0); m_push(16'h7FFF);
    do_scan(32'h7, lat, bok);
    rd(2'd2, r);
    rd(2'd3, ix);
    tests_run++;
    if (r !== 32'hFFFF_FFF0 || ix !== 32'd1 || lat !== 5) begin
      tests_failed++;
      $display("FAIL smin: got %h/%0d lat %0d expected fffffff0/1 lat 5", r, ix, lat);
    end
    do_scan(32'h5, lat, bok);
    rd(2'd2, r);
    rd(2'd3, ix);
    tests_run++;
    if (r !== 32'h0000_7FFF || ix !== 32'd2) begin
      tests_failed++;
      $display("FAIL smax_rescan: got %h/%0d expected 00007fff/2", r, ix);
    end
    do_scan(32'h1, lat, bok);
    rd(2'd2, r);
    tests_run++;
    if (r !== 32'h0000_FFF0) begin
      tests_failed++;
      $display("FAIL umax_zero_ext: got %h expected 0000fff0", r);
    end
  endtask

  task automatic test_overflow();
    int lat;
    bit bok;
    logic [31:0] s, r, ix, er, ei;
    m_clear();
    for (int i = 0; i < D + 2; i++) m_push(W'($urandom));
    rd(2'd0, s);
    tests_run++;
    if (s !== 32'h0000_1004) begin
      tests_failed++;
      $display("FAIL ovf_status: got %h expected 00001004", s);
    end
    do_scan(32'h1, lat, bok);
    ref_scan(1'b0, 1'b0, er, ei);
    rd(2'd2, r);
    rd(2'd3, ix);
    tests_run++;
    if (r !== er || ix !== ei || lat !== D + 2) begin
      tests_failed++;
      $display("FAIL ovf_scan: got %h/%0d lat %0d expected %h/%0d lat %0d",
               r, ix, lat, er, ei, D + 2);
    end
    m_clear();
    rd(2'd0, s);
    tests_run++;
    if (s !== 32'h0) begin
      tests_failed++;
      $display("FAIL ovf_clear: got %h expected 00000000", s);
    end
  endtask

  task automatic test_empty_start();
    logic [31:0] s, r, ix;
    m_clear();
    wr(2'd0, 32'h1);
    rd(2'd0, s);
    tests_run++;
    if (s !== 32'h0000_000A) begin
      tests_failed++;
      $display("FAIL empty_status: got %h expected 0000000a", s);
    end
    rd(2'd2, r);
    rd(2'd3, ix);
    tests_run++;
    if (r !== 32'h0 || ix !== 32'h0) begin
      tests_failed++;
      $display("FAIL empty_result: got %h/%h expected 0/0", r, ix);
    end
  endtask

  task automatic test_busy();
    int lat;
    logic [31:0] s, r, ix, er, ei, prev;
    m_clear();
    for (int i = 0; i < D; i++) m_push(W'($urandom));
    wr(2'd0, 32'h1);             // edge E
    rd(2'd0, s);                 // E+1
    tests_run++;
    if (s[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_flag: got status %h expected busy=1", s);
    end
    idle(1);                     // E+2
    wr(2'd1, 32'hAAAA);          // E+3, dropped
    wr(2'd0, 32'h1);             // E+4, ignored
    lat = -1;
    for (int k = 5; k <= 64; k++) begin
      rd(2'd0, s);
      if (s[1] && !s[0]) begin
        lat = k;
        break;
      end
    end
    tests_run++;
    if (lat !== D + 2 || s !== 32'h0000_1006) begin
      tests_failed++;
      $display("FAIL busy_ignore: got lat %0d status %h expected lat %0d status 00001006",
               lat, s, D + 2);
    end
    ref_scan(1'b0, 1'b0, er, ei);
    rd(2'd2, r);
    rd(2'd3, ix);
    tests_run++;
    if (r !== er || ix !== ei) begin
      tests_failed++;
      $display("FAIL busy_result: got %h/%0d expected %h/%0d", r, ix, er, ei);
    end
    prev = r;
    wr(2'd0, 32'h3);
    idle(3);
    m_clear();
    rd(2'd0, s);
    tests_run++;
    if (s !== 32'h0) begin
      tests_failed++;
      $display("FAIL clear_abort: got status %h expected 00000000", s);
    end
    idle(20);
    rd(2'd0, s);
    rd(2'd2, r);
    tests_run++;
    if (s !== 32'h0 || r !== prev) begin
      tests_failed++;
      $display("FAIL clear_keep: got status %h result %h expected 00000000 %h", s, r, prev);
    end
  endtask

  task automatic test_random();
    int n, lat;
    bit bok, mn, sg;
    logic [31:0] r, ix, c, er, ei;
    for (int it = 0; it < 8; it++) begin
      m_clear();
      n = $urandom_range(1, D);
      for (int i = 0; i < n; i++) begin
        // Narrow range on some passes to provoke ties.
        if (it[0]) m_push(W'($urandom_range(0, 3)) | 16'h8000);
        else       m_push(W'($urandom));
      end
      mn = 1'($urandom);
      sg = 1'($urandom);
      do_scan(32'h1 | (32'(mn) << 1) | (32'(sg) << 2), lat, bok);
      ref_scan(mn, sg, er, ei);
      rd(2'd2, r);
      rd(2'd3, ix);
      rd(2'd1, c);
      tests_run++;
      if (r !== er || ix !== ei || c !== 32'(n) || lat !== n + 2 || !bok) begin
        tests_failed++;
        $display("FAIL random_%0d: got %h/%0d cnt %0d lat %0d bok %0d expected %h/%0d cnt %0d lat %0d bok 1",
                 it, r, ix, c, lat, bok, er, ei, n, n + 2);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    bit bok;
    logic [31:0] r, s, ix, c;
    m_clear();
    for (int i = 0; i < 8; i++) m_push(W'($urandom) | 16'h0001);
    do_scan(32'h1, lat, bok);
    rd(2'd2, r);
    wr(2'd0, 32'h1);
    idle(4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (odata !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset_odata: got %h expected 00000000", odata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    rd(2'd0, s);
    rd(2'd2, r);
    rd(2'd3, ix);
    rd(2'd1, c);
    tests_run++;
    if (s !== 32'h0 || r !== 32'h0 || ix !== 32'h0 || c !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_scan: got %h %h %h %h expected all 0", s, r, ix, c);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_unsigned_max();
    test_signed_minmax();
    test_overflow();
    test_empty_start();
    test_busy();
    test_random();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
